// File: rtl/spu_sm_pkg.sv
// -----------------------------------------------------------------------------
// spu_sm_pkg
//   Shared definitions for the softmax unit (SPU) exp-LUT configuration path.
//   - Softmax FSM state encodings, as driven on sm_state by the softmax core.
//   - Encodings for the configuration loader FSM.
//   - Default geometry of the exp-LUT and the output scale shift.
// -----------------------------------------------------------------------------
package spu_sm_pkg;

  // Softmax FSM states seen on sm_state.
  localparam logic [2:0] SM_IDLE       = 3'b000;
  localparam logic [2:0] SM_EU_STAGE_A = 3'b001;
  localparam logic [2:0] SM_RECI       = 3'b011;
  localparam logic [2:0] SM_EU_STAGE_B = 3'b100;
  localparam logic [2:0] SM_MAX        = 3'b101;

  // Default exp-LUT geometry.
  localparam int SM_LUT_ENTRIES = 8;
  localparam int SM_ENTRY_W     = 16;
  localparam int SM_SHIFT_W     = 5;
  // expu datapath is 16 + MAX_SHIFT = 28 bits wide.
  localparam int SM_MAX_SHIFT   = 12;

  // Configuration loader FSM.
  //   S_IDLE : waiting for beat 0
  //   S_LOAD : collecting beats 1..LUT_ENTRIES (the last one is the shift word)
  //   S_PEND : shadow bank complete, waiting for the softmax FSM to go idle
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_PEND = 2'b10
  } cfg_state_e;

endpackage : spu_sm_pkg

// File: rtl/spu_sm_lut_cfg_loader.sv
// -----------------------------------------------------------------------------
// spu_sm_lut_cfg_loader
//   Writer side of the softmax exp-LUT configuration path. A 9-beat
//   valid/ready stream (LUT_ENTRIES LUT entries followed by one output scale
//   shift word) is staged in a shadow bank. The complete bank is committed in
//   one edge to the active sm_lut_config / output_scale_shift, and only while
//   the softmax FSM is IDLE, so expu never sees a half-written table.
//
// Ports
//   core_clk            clock
//   rst_n               asynchronous active-low reset
//   sm_state            softmax FSM state (commit allowed only in SM_IDLE)
//   cfg_valid/ready     beat handshake; ready drops while a commit is pending
//   cfg_data            beat payload; shift word in [SHIFT_W-1:0] of last beat
//   cfg_last            marks the shift word (final beat)
//   cfg_abort           drop the partially loaded / pending shadow bank
//   sm_lut_config       active LUT, entry k at [k*ENTRY_W +: ENTRY_W]
//   output_scale_shift  active output scale shift
//   lut_valid           at least one commit since reset
//   cfg_done            one-cycle pulse in the cycle after a commit edge
//   cfg_err             one-cycle pulse on a framing error
//   cfg_sat             committed shift was clamped; cleared by the next beat 0
// -----------------------------------------------------------------------------
module spu_sm_lut_cfg_loader
  import spu_sm_pkg::*;
#(
  parameter int LUT_ENTRIES = SM_LUT_ENTRIES,
  parameter int ENTRY_W     = SM_ENTRY_W,
  parameter int SHIFT_W     = SM_SHIFT_W,
  parameter int MAX_SHIFT   = SM_MAX_SHIFT
) (
  input  logic                           core_clk,
  input  logic                           rst_n,
  input  logic [2:0]                     sm_state,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [ENTRY_W-1:0]             cfg_data,
  input  logic                           cfg_last,
  input  logic                           cfg_abort,
  output logic [LUT_ENTRIES*ENTRY_W-1:0] sm_lut_config,
  output logic [SHIFT_W-1:0]             output_scale_shift,
  output logic                           lut_valid,
  output logic                           cfg_done,
  output logic                           cfg_err,
  output logic                           cfg_sat
);

  localparam int                 IDX_W      = $clog2(LUT_ENTRIES);
  // beat_cnt value at which the shift word is expected.
  localparam logic [3:0]         SHIFT_BEAT = 4'(LUT_ENTRIES);
  localparam logic [SHIFT_W-1:0] SHIFT_LIM  = SHIFT_W'(MAX_SHIFT);

  // Clamp the requested shift to the legal range; MSB of the result flags
  // that clamping happened.
  function automatic logic [SHIFT_W:0] clamp_shift(input logic [SHIFT_W-1:0] raw);
    if (raw > SHIFT_LIM) begin
      return {1'b1, SHIFT_LIM};
    end
    return {1'b0, raw};
  endfunction

  cfg_state_e                      state_q, state_d;
  logic [3:0]                      beat_cnt_q, beat_cnt_d;
  logic [ENTRY_W-1:0]              shadow_q [LUT_ENTRIES];
  logic [ENTRY_W-1:0]              shadow_d [LUT_ENTRIES];
  logic [SHIFT_W-1:0]              shadow_shift_q, shadow_shift_d;
  logic                            shadow_sat_q, shadow_sat_d;
  logic [LUT_ENTRIES*ENTRY_W-1:0]  lut_q, lut_d;
  logic [SHIFT_W-1:0]              shift_q, shift_d;
  logic                            lut_valid_q, lut_valid_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic                            sat_q, sat_d;

  logic                            accept;
  logic [SHIFT_W:0]                clamp_res;

  assign cfg_ready = (state_q != S_PEND);
  assign accept    = cfg_valid & cfg_ready;
  assign clamp_res = clamp_shift(cfg_data[SHIFT_W-1:0]);

  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    shadow_d       = shadow_q;
    shadow_shift_d = shadow_shift_q;
    shadow_sat_d   = shadow_sat_q;
    lut_d          = lut_q;
    shift_d        = shift_q;
    lut_valid_d    = lut_valid_q;
    sat_d          = sat_q;
    done_d         = 1'b0;
    err_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An abort here has nothing to discard, but it still swallows any
        // beat offered in the same cycle.
        if (accept && !cfg_abort) begin
          sat_d = 1'b0;
          if (cfg_last) begin
            err_d = 1'b1;
          end else begin
            shadow_d[0] = cfg_data;
            beat_cnt_d  = 4'd1;
            state_d     = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (cfg_abort) begin
          beat_cnt_d = 4'd0;
          state_d    = S_IDLE;
        end else if (accept) begin
          if (beat_cnt_q == SHIFT_BEAT) begin
            beat_cnt_d = 4'd0;
            if (cfg_last) begin
              shadow_shift_d = clamp_res[SHIFT_W-1:0];
              shadow_sat_d   = clamp_res[SHIFT_W];
              state_d        = S_PEND;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else if (cfg_last) begin
            // Frame ended early: the partial shadow is simply abandoned and
            // fully overwritten by the next frame.
            err_d      = 1'b1;
            beat_cnt_d = 4'd0;
            state_d    = S_IDLE;
          end else begin
            shadow_d[beat_cnt_q[IDX_W-1:0]] = cfg_data;
            beat_cnt_d                      = beat_cnt_q + 4'd1;
          end
        end
      end

      S_PEND: begin
        if (cfg_abort) begin
          state_d = S_IDLE;
        end else if (sm_state == SM_IDLE) begin
          for (int k = 0; k < LUT_ENTRIES; k++) begin
            lut_d[k*ENTRY_W +: ENTRY_W] = shadow_q[k];
          end
          shift_d     = shadow_shift_q;
          sat_d       = shadow_sat_q;
          lut_valid_d = 1'b1;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      beat_cnt_q     <= 4'd0;
      for (int k = 0; k < LUT_ENTRIES; k++) begin
        shadow_q[k] <= '0;
      end
      shadow_shift_q <= '0;
      shadow_sat_q   <= 1'b0;
      lut_q          <= '0;
      shift_q        <= '0;
      lut_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      shadow_q       <= shadow_d;
      shadow_shift_q <= shadow_shift_d;
      shadow_sat_q   <= shadow_sat_d;
      lut_q          <= lut_d;
      shift_q        <= shift_d;
      lut_valid_q    <= lut_valid_d;
      done_q         <= done_d;
      err_q          <= err_d;
      sat_q          <= sat_d;
    end
  end

  assign sm_lut_config      = lut_q;
  assign output_scale_shift = shift_q;
  assign lut_valid          = lut_valid_q;
  assign cfg_done           = done_q;
  assign cfg_err            = err_q;
  assign cfg_sat            = sat_q;

endmodule : spu_sm_lut_cfg_loader

// File: tb/tb_spu_sm_lut_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_spu_sm_lut_cfg_loader
//   Self-checking bench for the softmax exp-LUT configuration loader.
//   A table of complete frames is loaded in a loop; each frame's expected
//   commit is queued and checked when cfg_done is seen. Hand-written
//   sequences cover framing errors, aborts and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_spu_sm_lut_cfg_loader;
  import spu_sm_pkg::*;

  logic         core_clk = 1'b0;
  logic         rst_n;
  logic [2:0]   sm_state;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [15:0]  cfg_data;
  logic         cfg_last;
  logic         cfg_abort;
  logic [127:0] sm_lut_config;
  logic [4:0]   output_scale_shift;
  logic         lut_valid;
  logic         cfg_done;
  logic         cfg_err;
  logic         cfg_sat;

  spu_sm_lut_cfg_loader dut (
    .core_clk           (core_clk),
    .rst_n              (rst_n),
    .sm_state           (sm_state),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_data           (cfg_data),
    .cfg_last           (cfg_last),
    .cfg_abort          (cfg_abort),
    .sm_lut_config      (sm_lut_config),
    .output_scale_shift (output_scale_shift),
    .lut_valid          (lut_valid),
    .cfg_done           (cfg_done),
    .cfg_err            (cfg_err),
    .cfg_sat            (cfg_sat)
  );

  always #5 core_clk = ~core_clk;

  // One frame: 8 entries (e[0] is beat 0), shift word, softmax state during
  // the load, cycles the softmax stays busy, expected committed shift/sat.
  typedef struct packed {
    logic [7:0][15:0] e;
    logic [15:0]      shw;
    logic [2:0]       sm;
    logic [7:0]       busy;
    logic [4:0]       exp_shift;
    logic             exp_sat;
  } vec_t;

  typedef struct packed {
    logic [127:0] lut;
    logic [4:0]   shift;
    logic         sat;
  } exp_t;

  exp_t         sb_q[$];
  vec_t         tbl[7];
  int           errors = 0;
  int           checks = 0;
  logic [127:0] prev_lut;
  logic [4:0]   prev_shift;
  logic [127:0] last_lut;

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Commit scoreboard and active-register stability, sampled mid-cycle.
  always @(negedge core_clk) begin
    if (rst_n === 1'b1) begin
      if (cfg_done) begin
        if (sb_q.size() == 0) begin
          chk1("unexpected_done", cfg_done, 1'b0);
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          chkw("commit_lut", sm_lut_config, x.lut);
          chkw("commit_shift", 128'(output_scale_shift), 128'(x.shift));
          chk1("commit_sat", cfg_sat, x.sat);
          chk1("commit_lut_valid", lut_valid, 1'b1);
        end
      end else begin
        chkw("hold_lut", sm_lut_config, prev_lut);
        chkw("hold_shift", 128'(output_scale_shift), 128'(prev_shift));
      end
      if (cfg_done || cfg_err) chk1("done_err_exclusive", cfg_done & cfg_err, 1'b0);
    end
    prev_lut   = sm_lut_config;
    prev_shift = output_scale_shift;
  end

  task automatic cyc();
    @(posedge core_clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last);
    int n;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    n = 0;
    while (!cfg_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!cfg_ready) chk1("ready_timeout", cfg_ready, 1'b1);
    cyc();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    sm_state = v.sm;
    for (int k = 0; k < 8; k++) begin
      send_beat(v.e[k], 1'b0);
      if (k == 0) chk1("sat_clear_on_beat0", cfg_sat, 1'b0);
    end
    send_beat(v.shw, 1'b1);
    chk1("pend_ready_low", cfg_ready, 1'b0);
    chk1("no_early_done", cfg_done, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t x;
    int   bad;
    x.lut   = v.e;
    x.shift = v.exp_shift;
    x.sat   = v.exp_sat;
    sb_q.push_back(x);
    send_frame(v);
    if (v.busy != 8'd0) begin
      bad = 0;
      for (int i = 0; i < int'(v.busy); i++) begin
        cyc();
        if (cfg_ready || cfg_done) bad++;
      end
      chkw("busy_hold", 128'(bad), 128'd0);
      sm_state = SM_IDLE;
    end
    cyc();
    chk1("commit_latency", cfg_done, 1'b1);
    chk1("ready_with_done", cfg_ready, 1'b1);
    cyc();
    chk1("done_pulse", cfg_done, 1'b0);
    last_lut = v.e;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chkw({tag, "_lut"}, sm_lut_config, 128'd0);
    chkw({tag, "_shift"}, 128'(output_scale_shift), 128'd0);
    chk1({tag, "_lut_valid"}, lut_valid, 1'b0);
    chk1({tag, "_done"}, cfg_done, 1'b0);
    chk1({tag, "_err"}, cfg_err, 1'b0);
    chk1({tag, "_sat"}, cfg_sat, 1'b0);
    chk1({tag, "_ready"}, cfg_ready, 1'b1);
  endtask

  initial begin
    vec_t h;

    tbl[0] = '{e: {16'h8000, 16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h3000, 16'h2000, 16'h1000},
               shw: 16'h0003, sm: SM_IDLE, busy: 8'd0, exp_shift: 5'd3, exp_sat: 1'b0};
    tbl[1] = '{e: {16'hF00D, 16'h0001, 16'hFFFF, 16'h1234, 16'h8001, 16'h00FF, 16'hABCD, 16'h0F0F},
               shw: 16'h0007, sm: SM_EU_STAGE_A, busy: 8'd20, exp_shift: 5'd7, exp_sat: 1'b0};
    tbl[2] = '{e: {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888},
               shw: 16'h001F, sm: SM_RECI, busy: 8'd3, exp_shift: 5'd12, exp_sat: 1'b1};
    tbl[3] = '{e: {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000},
               shw: 16'h0002, sm: SM_IDLE, busy: 8'd0, exp_shift: 5'd2, exp_sat: 1'b0};
    tbl[4] = '{e: {16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E, 16'h0F10},
               shw: 16'hFFED, sm: SM_MAX, busy: 8'd2, exp_shift: 5'd12, exp_sat: 1'b1};
    tbl[5] = '{e: {16'hA5A5, 16'h5A5A, 16'hFFFE, 16'h0002, 16'h7FFF, 16'h8000, 16'h0000, 16'hDEAD},
               shw: 16'h000C, sm: SM_EU_STAGE_B, busy: 8'd1, exp_shift: 5'd12, exp_sat: 1'b0};
    tbl[6] = '{e: {16'h0808, 16'h0707, 16'h0606, 16'h0505, 16'h0404, 16'h0303, 16'h0202, 16'h0101},
               shw: 16'hFFE5, sm: SM_IDLE, busy: 8'd0, exp_shift: 5'd5, exp_sat: 1'b0};

    rst_n     = 1'b0;
    sm_state  = SM_IDLE;
    cfg_valid = 1'b0;
    cfg_data  = 16'h0000;
    cfg_last  = 1'b0;
    cfg_abort = 1'b0;
    last_lut  = 128'd0;
    repeat (2) @(posedge core_clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // Table-driven full frames.
    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i]);
    end

    // cfg_last on beat 4: error, active LUT untouched, next frame fine.
    sm_state = SM_IDLE;
    for (int k = 0; k < 4; k++) send_beat(16'hAAA0 + 16'(k), 1'b0);
    send_beat(16'h5555, 1'b1);
    chk1("early_last_err", cfg_err, 1'b1);
    chk1("early_last_no_done", cfg_done, 1'b0);
    chk1("early_last_ready", cfg_ready, 1'b1);
    cyc();
    chk1("err_pulse", cfg_err, 1'b0);
    chkw("early_last_lut_kept", sm_lut_config, last_lut);
    run_vec(tbl[1]);

    // Shift word without cfg_last: error.
    for (int k = 0; k < 9; k++) send_beat(16'h0100 + 16'(k), 1'b0);
    chk1("no_last_err", cfg_err, 1'b1);
    cyc();
    // cfg_last on beat 0: error, stays idle.
    send_beat(16'h0004, 1'b1);
    chk1("beat0_last_err", cfg_err, 1'b1);
    cyc();
    run_vec(tbl[3]);

    // Abort in S_LOAD with a same-cycle beat, then abort in S_IDLE with a beat.
    for (int k = 0; k < 3; k++) send_beat(16'hBEE0 + 16'(k), 1'b0);
    cfg_abort = 1'b1;
    send_beat(16'hDEAD, 1'b0);
    chk1("abort_load_no_err", cfg_err, 1'b0);
    send_beat(16'hDEAF, 1'b0);
    cfg_abort = 1'b0;
    chk1("abort_idle_no_err", cfg_err, 1'b0);
    h = tbl[0];
    h.e[3] = 16'h3C3C;
    h.shw  = 16'h0009;
    h.exp_shift = 5'd9;
    run_vec(h);

    // Abort in S_PEND in the same cycle the softmax FSM returns to IDLE.
    h = tbl[2];
    h.sm = SM_EU_STAGE_A;
    send_frame(h);
    sm_state  = SM_IDLE;
    cfg_abort = 1'b1;
    cyc();
    cfg_abort = 1'b0;
    chk1("pend_abort_no_done", cfg_done, 1'b0);
    chk1("pend_abort_no_err", cfg_err, 1'b0);
    chk1("pend_abort_ready", cfg_ready, 1'b1);
    chkw("pend_abort_lut_kept", sm_lut_config, last_lut);
    cyc();
    chk1("pend_abort_still_no_done", cfg_done, 1'b0);

    // Reset after beat 5 of a new frame.
    sm_state = SM_IDLE;
    for (int k = 0; k < 6; k++) send_beat(16'h7770 + 16'(k), 1'b0);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midload_reset");
    cyc();
    cyc();
    rst_n    = 1'b1;
    last_lut = 128'd0;
    cyc();
    chkw("post_reset_lut", sm_lut_config, 128'd0);
    run_vec(tbl[5]);

    chkw("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_spu_sm_lut_cfg_loader
